// File: rtl/vce2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vce2_pkg                                                     |
// | Description : Shared types and default widths for the vector element       |
// |               sequencer (state encoding, default data/address/vlen sizes). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package vce2_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned DefVlenWords = 8;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    AGU_LD   = 4'd1,
    AGU_WAIT = 4'd2,
    RS1_ISS  = 4'd3,
    RS1_REQ  = 4'd4,
    RS1_RESP = 4'd5,
    RS2_ISS  = 4'd6,
    RS2_REQ  = 4'd7,
    RS2_RESP = 4'd8,
    EXEC     = 4'd9,
    RD_ISS   = 4'd10,
    RD_REQ   = 4'd11,
    RD_RESP  = 4'd12,
    DONE     = 4'd13
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/vce2_mem_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vce2_mem_port                                                |
// | Description : Single-outstanding OBI-style access port. An issue pulse     |
// |               latches address/we/wdata; req is held with a stable address  |
// |               until grant, then the port waits for the response.           |
// | Revision    : 1.0 - initial release                                        |
// | Ports       : clk_i, rst_ni     clock, synchronous active-low reset        |
// |               i_issue           start one access (latch addr/we/wdata)     |
// |               i_we/i_addr/i_wdata  access attributes                       |
// |               o_granted         req accepted this cycle                    |
// |               o_resp            response arrives this cycle                |
// |               data_*            memory-side request/response signals       |
// +----------------------------------------------------------------------------+
module vce2_mem_port #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 i_issue,
  input  logic                 i_we,
  input  logic [AddrWidth-1:0] i_addr,
  input  logic [DataWidth-1:0] i_wdata,
  output logic                 o_granted,
  output logic                 o_resp,
  output logic                 data_req_o,
  input  logic                 data_gnt_i,
  input  logic                 data_rvalid_i,
  output logic                 data_we_o,
  output logic [AddrWidth-1:0] data_addr_o,
  output logic [DataWidth-1:0] data_wdata_o
);

  logic                 r_req;
  logic                 r_wait;
  logic                 r_we;
  logic [AddrWidth-1:0] r_addr;
  logic [DataWidth-1:0] r_wdata;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_req   <= 1'b0;
      r_wait  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (i_issue) begin
      r_req   <= 1'b1;
      r_we    <= i_we;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
    end else if (r_req && data_gnt_i) begin
      r_req  <= 1'b0;
      r_wait <= 1'b1;
    end else if (r_wait && data_rvalid_i) begin
      r_wait <= 1'b0;
    end
  end

  // A response only counts while an access is outstanding, so stray rvalid
  // pulses between accesses are dropped here.
  assign o_granted    = r_req & data_gnt_i;
  assign o_resp       = r_wait & data_rvalid_i;
  assign data_req_o   = r_req;
  assign data_we_o    = r_req & r_we;
  assign data_addr_o  = r_addr;
  assign data_wdata_o = r_wdata;

endmodule
`default_nettype wire

// File: rtl/vce2_vrf_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vce2_vrf_seq                                                 |
// | Description : Element sequencer upstream of the vector AGU. Loads the AGU, |
// |               then per element reads rs1/rs2, hands them to the ALU and    |
// |               writes the result to rd, pulsing each AGU get strobe once.   |
// | Revision    : 1.0 - initial release                                        |
// | Ports       : clk_i, rst_ni      clock, synchronous active-low reset       |
// |               start_i, vl_i      start request and element count           |
// |               busy_o, done_o     status / one-cycle completion pulse       |
// |               agu_*              AGU load/ready/get strobes and address    |
// |               data_*             OBI-style memory port                     |
// |               opa_o/opb_o/op_valid_o, res_i/res_valid_i  ALU handshake     |
// +----------------------------------------------------------------------------+
module vce2_vrf_seq
  import vce2_pkg::*;
#(
  parameter int unsigned DataWidth = DefDataWidth,
  parameter int unsigned AddrWidth = DefAddrWidth,
  parameter int unsigned VlenWords = DefVlenWords,
  parameter int unsigned VlWidth   = $clog2(VlenWords + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [VlWidth-1:0]   vl_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 agu_load_o,
  input  logic                 agu_ready_i,
  output logic                 agu_get_rs1_o,
  output logic                 agu_get_rs2_o,
  output logic                 agu_get_rd_o,
  input  logic [AddrWidth-1:0] agu_addr_i,
  output logic                 data_req_o,
  input  logic                 data_gnt_i,
  input  logic                 data_rvalid_i,
  output logic                 data_we_o,
  output logic [AddrWidth-1:0] data_addr_o,
  output logic [DataWidth-1:0] data_wdata_o,
  input  logic [DataWidth-1:0] data_rdata_i,
  output logic [DataWidth-1:0] opa_o,
  output logic [DataWidth-1:0] opb_o,
  output logic                 op_valid_o,
  input  logic [DataWidth-1:0] res_i,
  input  logic                 res_valid_i
);

  localparam logic [VlWidth-1:0] c_VLEN = VlWidth'(VlenWords);

  seq_state_e           r_state;
  logic [VlWidth-1:0]   r_vl;
  logic [VlWidth-1:0]   r_cnt;
  logic [DataWidth-1:0] r_opa;
  logic [DataWidth-1:0] r_opb;
  logic [DataWidth-1:0] r_res;
  logic                 r_agu_load;
  logic                 r_get_rs1;
  logic                 r_get_rs2;
  logic                 r_get_rd;
  logic                 r_done;
  logic                 r_op_valid;

  logic                 w_issue;
  logic                 w_granted;
  logic                 w_resp;
  logic [VlWidth-1:0]   w_cnt_inc;
  logic [VlWidth-1:0]   w_vl_clamped;

  assign w_issue      = (r_state == RS1_ISS) || (r_state == RS2_ISS) || (r_state == RD_ISS);
  assign w_cnt_inc    = r_cnt + VlWidth'(1);
  assign w_vl_clamped = (vl_i > c_VLEN) ? c_VLEN : vl_i;

  // Strobe registers are set on the transition into their state, so each is
  // high for exactly the cycle the FSM spends there.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_vl       <= '0;
      r_cnt      <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_res      <= '0;
      r_agu_load <= 1'b0;
      r_get_rs1  <= 1'b0;
      r_get_rs2  <= 1'b0;
      r_get_rd   <= 1'b0;
      r_done     <= 1'b0;
      r_op_valid <= 1'b0;
    end else begin
      r_agu_load <= 1'b0;
      r_get_rs1  <= 1'b0;
      r_get_rs2  <= 1'b0;
      r_get_rd   <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_cnt <= '0;
            if (vl_i == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_vl       <= w_vl_clamped;
              r_state    <= AGU_LD;
              r_agu_load <= 1'b1;
            end
          end
        end
        AGU_LD:   r_state <= AGU_WAIT;
        AGU_WAIT: begin
          if (agu_ready_i) begin
            r_state   <= RS1_ISS;
            r_get_rs1 <= 1'b1;
          end
        end
        RS1_ISS:  r_state <= RS1_REQ;
        RS1_REQ:  if (w_granted) r_state <= RS1_RESP;
        RS1_RESP: begin
          if (w_resp) begin
            r_opa     <= data_rdata_i;
            r_state   <= RS2_ISS;
            r_get_rs2 <= 1'b1;
          end
        end
        RS2_ISS:  r_state <= RS2_REQ;
        RS2_REQ:  if (w_granted) r_state <= RS2_RESP;
        RS2_RESP: begin
          if (w_resp) begin
            r_opb      <= data_rdata_i;
            r_state    <= EXEC;
            r_op_valid <= 1'b1;
          end
        end
        EXEC: begin
          if (res_valid_i) begin
            r_res      <= res_i;
            r_op_valid <= 1'b0;
            r_state    <= RD_ISS;
            r_get_rd   <= 1'b1;
          end
        end
        RD_ISS:   r_state <= RD_REQ;
        RD_REQ:   if (w_granted) r_state <= RD_RESP;
        RD_RESP: begin
          if (w_resp) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == r_vl) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= RS1_ISS;
              r_get_rs1 <= 1'b1;
            end
          end
        end
        DONE:     r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

  vce2_mem_port #(
    .DataWidth (DataWidth),
    .AddrWidth (AddrWidth)
  ) u_mem_port (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .i_issue       (w_issue),
    .i_we          (r_state == RD_ISS),
    .i_addr        (agu_addr_i),
    .i_wdata       (r_res),
    .o_granted     (w_granted),
    .o_resp        (w_resp),
    .data_req_o    (data_req_o),
    .data_gnt_i    (data_gnt_i),
    .data_rvalid_i (data_rvalid_i),
    .data_we_o     (data_we_o),
    .data_addr_o   (data_addr_o),
    .data_wdata_o  (data_wdata_o)
  );

  assign busy_o        = (r_state != IDLE);
  assign done_o        = r_done;
  assign agu_load_o    = r_agu_load;
  assign agu_get_rs1_o = r_get_rs1;
  assign agu_get_rs2_o = r_get_rs2;
  assign agu_get_rd_o  = r_get_rd;
  assign opa_o         = r_opa;
  assign opb_o         = r_opb;
  assign op_valid_o    = r_op_valid;

endmodule
`default_nettype wire

// File: tb/tb_vce2_vrf_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vce2_vrf_seq                                              |
// | Description : Directed self-checking bench for vce2_vrf_seq with a simple  |
// |               AGU, memory (configurable grant stall) and adder ALU model.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_vce2_vrf_seq;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_ni, start_i;
  logic [3:0]    vl_i;
  logic          busy_o, done_o, agu_load_o, agu_ready_i;
  logic          agu_get_rs1_o, agu_get_rs2_o, agu_get_rd_o;
  logic [AW-1:0] agu_addr_i, data_addr_o;
  logic          data_req_o, data_gnt_i, data_rvalid_i, data_we_o;
  logic [DW-1:0] data_wdata_o, data_rdata_i, opa_o, opb_o, res_i;
  logic          op_valid_o, res_valid_i;

  always #5 clk = ~clk;

  vce2_vrf_seq #(.DataWidth(DW), .AddrWidth(AW), .VlenWords(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .vl_i(vl_i),
    .busy_o(busy_o), .done_o(done_o), .agu_load_o(agu_load_o), .agu_ready_i(agu_ready_i),
    .agu_get_rs1_o(agu_get_rs1_o), .agu_get_rs2_o(agu_get_rs2_o), .agu_get_rd_o(agu_get_rd_o),
    .agu_addr_i(agu_addr_i), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_we_o(data_we_o), .data_addr_o(data_addr_o),
    .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i), .opa_o(opa_o), .opb_o(opb_o),
    .op_valid_o(op_valid_o), .res_i(res_i), .res_valid_i(res_valid_i)
  );

  int checks = 0;
  int errors = 0;

  // Environment state
  logic [31:0] mem [0:255];
  logic [31:0] p_rs1, p_rs2, p_rd, pend_addr, last_addr;
  logic        ld_seen, pend, pend_we, last_req, last_gnt;
  logic [2:0]  prev_get;
  int          stall_cfg = 0;
  int          stall_cnt = 0;
  bit          inj_rvalid = 0;
  bit          inj_res = 0;

  // Monitor counters (only written by the monitor)
  int n_g1 = 0, n_g2 = 0, n_g3 = 0, n_r1 = 0, n_r2 = 0, n_r3 = 0;
  int n_multi = 0, n_done = 0, n_load = 0, n_txn = 0, n_viol = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  // Snapshots taken by the stimulus process
  int s_g1, s_g2, s_g3, s_r1, s_r2, s_r3, s_multi, s_done, s_load, s_txn, s_viol, s_wr;

  assign agu_addr_i = agu_get_rs1_o ? p_rs1 : agu_get_rs2_o ? p_rs2 : agu_get_rd_o ? p_rd : '0;

  always @(posedge clk) begin
    if (!rst_ni) begin
      p_rs1 <= 32'h100; p_rs2 <= 32'h200; p_rd <= 32'h300;
      ld_seen <= 1'b0; pend <= 1'b0; pend_we <= 1'b0; pend_addr <= '0;
      prev_get <= '0; last_req <= 1'b0; last_gnt <= 1'b0; last_addr <= '0;
    end else begin
      ld_seen <= agu_load_o;
      if (agu_load_o) begin
        p_rs1 <= 32'h100; p_rs2 <= 32'h200; p_rd <= 32'h300;
      end else begin
        if (agu_get_rs1_o) p_rs1 <= p_rs1 + 32'd4;
        if (agu_get_rs2_o) p_rs2 <= p_rs2 + 32'd4;
        if (agu_get_rd_o)  p_rd  <= p_rd + 32'd4;
      end
      pend      <= data_req_o && data_gnt_i;
      pend_we   <= data_we_o;
      pend_addr <= data_addr_o;
      if (data_req_o && data_gnt_i) begin
        n_txn++;
        if (data_we_o) begin
          wr_addr_q.push_back(data_addr_o);
          wr_data_q.push_back(data_wdata_o);
        end
      end
      if (agu_get_rs1_o) n_g1++;
      if (agu_get_rs2_o) n_g2++;
      if (agu_get_rd_o)  n_g3++;
      if (agu_get_rs1_o && !prev_get[0]) n_r1++;
      if (agu_get_rs2_o && !prev_get[1]) n_r2++;
      if (agu_get_rd_o  && !prev_get[2]) n_r3++;
      if (int'(agu_get_rs1_o) + int'(agu_get_rs2_o) + int'(agu_get_rd_o) > 1) n_multi++;
      if (done_o) n_done++;
      if (agu_load_o) n_load++;
      if (last_req && !last_gnt && (!data_req_o || data_addr_o != last_addr)) n_viol++;
      prev_get  <= {agu_get_rd_o, agu_get_rs2_o, agu_get_rs1_o};
      last_req  <= data_req_o;
      last_gnt  <= data_gnt_i;
      last_addr <= data_addr_o;
    end
  end

  // Environment responses, driven mid-cycle
  always @(negedge clk) begin
    agu_ready_i   = ld_seen;
    data_rvalid_i = pend;
    data_rdata_i  = (pend && !pend_we) ? mem[pend_addr[9:2]] : '0;
    if (inj_rvalid && !pend && (agu_get_rs1_o || agu_get_rs2_o || agu_get_rd_o)) begin
      data_rvalid_i = 1'b1;
      data_rdata_i  = 32'h0BAD_0BAD;
    end
    if (data_req_o && rst_ni) begin
      if (stall_cnt >= stall_cfg) begin
        data_gnt_i = 1'b1;
        stall_cnt  = 0;
      end else begin
        data_gnt_i = 1'b0;
        stall_cnt++;
      end
    end else begin
      data_gnt_i = 1'b0;
      stall_cnt  = 0;
    end
    res_valid_i = op_valid_o;
    res_i       = op_valid_o ? (opa_o + opb_o) : '0;
    if (inj_res && !op_valid_o) begin
      res_valid_i = 1'b1;
      res_i       = 32'h0000_DEAD;
    end
  end

  task automatic snap();
    s_g1 = n_g1; s_g2 = n_g2; s_g3 = n_g3; s_r1 = n_r1; s_r2 = n_r2; s_r3 = n_r3;
    s_multi = n_multi; s_done = n_done; s_load = n_load; s_txn = n_txn; s_viol = n_viol;
    s_wr = wr_addr_q.size();
  endtask

  // Starts one op and returns cycles from start acceptance to done_o.
  task automatic run_op(input logic [3:0] vl, output int lat, output bit to);
    @(negedge clk); start_i = 1'b1; vl_i = vl;
    @(negedge clk); start_i = 1'b0; lat = 1;
    while (!done_o && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    to = !done_o;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [255:0] all;
    rst_ni = 1'b0; start_i = 1'b0; vl_i = '0;
    repeat (3) @(negedge clk);
    all = {busy_o, done_o, agu_load_o, agu_get_rs1_o, agu_get_rs2_o, agu_get_rd_o, data_req_o,
           data_we_o, data_addr_o, data_wdata_o, opa_o, opb_o, op_valid_o};
    checks++;
    if (all !== '0) begin errors++; $display("FAIL reset_outputs: got %0h expected 0", all); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vl_zero();
    int lat; bit to;
    snap();
    @(negedge clk); start_i = 1'b1; vl_i = 4'd0;
    @(negedge clk); start_i = 1'b0;
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++; $display("FAIL vl0_done_next: got done=%b busy=%b expected 1 1", done_o, busy_o);
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL vl0_back_idle: got done=%b busy=%b expected 0 0", done_o, busy_o);
    end
    checks++;
    if (n_done - s_done != 1) begin errors++; $display("FAIL vl0_done_count: got %0d expected 1", n_done - s_done); end
    checks++;
    if ((n_load - s_load) + (n_txn - s_txn) + (n_g1 - s_g1) + (n_g2 - s_g2) + (n_g3 - s_g3) != 0) begin
      errors++; $display("FAIL vl0_no_traffic: got load=%0d txn=%0d expected 0", n_load - s_load, n_txn - s_txn);
    end
    lat = 0; to = 0;
  endtask

  task automatic test_single();
    int lat; bit to;
    stall_cfg = 0;
    snap();
    run_op(4'd1, lat, to);
    checks++;
    if (to || lat != 13) begin errors++; $display("FAIL single_latency: got %0d (timeout=%b) expected 13", lat, to); end
    checks++;
    if (opa_o !== 32'd5 || opb_o !== 32'd7) begin
      errors++; $display("FAIL single_operands: got %0h %0h expected 5 7", opa_o, opb_o);
    end
    checks++;
    if (wr_addr_q.size() - s_wr != 1) begin
      errors++; $display("FAIL single_write_count: got %0d expected 1", wr_addr_q.size() - s_wr);
    end else begin
      checks++;
      if (wr_addr_q[s_wr] !== 32'h300 || wr_data_q[s_wr] !== 32'd12) begin
        errors++; $display("FAIL single_write: got %0h<=%0h expected 300<=c", wr_addr_q[s_wr], wr_data_q[s_wr]);
      end
    end
    checks++;
    if (n_r1 - s_r1 != 1 || n_r2 - s_r2 != 1 || n_r3 - s_r3 != 1 ||
        n_g1 - s_g1 != 1 || n_g2 - s_g2 != 1 || n_g3 - s_g3 != 1) begin
      errors++; $display("FAIL single_get_pulses: got %0d %0d %0d expected 1 1 1", n_g1 - s_g1, n_g2 - s_g2, n_g3 - s_g3);
    end
    checks++;
    if (n_done - s_done != 1 || n_txn - s_txn != 3 || n_load - s_load != 1) begin
      errors++; $display("FAIL single_counts: got done=%0d txn=%0d load=%0d expected 1 3 1",
                         n_done - s_done, n_txn - s_txn, n_load - s_load);
    end
  endtask

  task automatic test_stall();
    int lat; bit to;
    stall_cfg = 4;
    snap();
    run_op(4'd3, lat, to);
    stall_cfg = 0;
    checks++;
    if (to || lat != 69) begin errors++; $display("FAIL stall_latency: got %0d (timeout=%b) expected 69", lat, to); end
    checks++;
    if (n_viol - s_viol != 0) begin errors++; $display("FAIL stall_req_stable: got %0d violations expected 0", n_viol - s_viol); end
    checks++;
    if (n_r1 - s_r1 != 3 || n_r2 - s_r2 != 3 || n_r3 - s_r3 != 3 ||
        n_g1 - s_g1 != 3 || n_g2 - s_g2 != 3 || n_g3 - s_g3 != 3) begin
      errors++; $display("FAIL stall_get_pulses: got rises %0d %0d %0d highs %0d %0d %0d expected all 3",
                         n_r1 - s_r1, n_r2 - s_r2, n_r3 - s_r3, n_g1 - s_g1, n_g2 - s_g2, n_g3 - s_g3);
    end
    checks++;
    if (n_txn - s_txn != 9) begin errors++; $display("FAIL stall_txn: got %0d expected 9", n_txn - s_txn); end
    checks++;
    if (wr_addr_q.size() - s_wr != 3) begin
      errors++; $display("FAIL stall_write_count: got %0d expected 3", wr_addr_q.size() - s_wr);
    end else begin
      checks++;
      if (wr_addr_q[s_wr+2] !== 32'h308 || wr_data_q[s_wr+2] !== 32'd16 || wr_data_q[s_wr+1] !== 32'd14) begin
        errors++; $display("FAIL stall_writes: got %0h<=%0h expected 308<=10", wr_addr_q[s_wr+2], wr_data_q[s_wr+2]);
      end
    end
    checks++;
    if (n_multi - s_multi != 0) begin errors++; $display("FAIL stall_one_get: got %0d overlaps expected 0", n_multi - s_multi); end
  endtask

  task automatic test_clamp();
    int lat; bit to;
    snap();
    run_op(4'd12, lat, to);
    checks++;
    if (to || lat != 83) begin errors++; $display("FAIL clamp_latency: got %0d (timeout=%b) expected 83", lat, to); end
    checks++;
    if (wr_addr_q.size() - s_wr != 8) begin
      errors++; $display("FAIL clamp_write_count: got %0d expected 8", wr_addr_q.size() - s_wr);
    end else begin
      checks++;
      if (wr_addr_q[s_wr+7] !== 32'h31C || wr_data_q[s_wr+7] !== 32'd26) begin
        errors++; $display("FAIL clamp_last_write: got %0h<=%0h expected 31c<=1a", wr_addr_q[s_wr+7], wr_data_q[s_wr+7]);
      end
    end
    checks++;
    if (n_done - s_done != 1) begin errors++; $display("FAIL clamp_done: got %0d expected 1", n_done - s_done); end
  endtask

  task automatic test_ignored();
    int lat;
    snap();
    inj_rvalid = 1; inj_res = 1;
    @(negedge clk); start_i = 1'b1; vl_i = 4'd2;
    @(negedge clk); start_i = 1'b0; lat = 1;
    while (!done_o && lat < 500) begin
      if (lat == 3) begin start_i = 1'b1; vl_i = 4'd5; end
      if (lat == 15) start_i = 1'b0;
      @(negedge clk);
      lat++;
    end
    start_i = 1'b0;
    checks++;
    if (lat != 23) begin errors++; $display("FAIL ignore_latency: got %0d expected 23", lat); end
    @(negedge clk);
    inj_rvalid = 0; inj_res = 0;
    checks++;
    if (busy_o !== 1'b0 || n_load - s_load != 1 || n_done - s_done != 1) begin
      errors++; $display("FAIL ignore_no_restart: got busy=%b load=%0d done=%0d expected 0 1 1",
                         busy_o, n_load - s_load, n_done - s_done);
    end
    checks++;
    if (wr_addr_q.size() - s_wr != 2 || n_txn - s_txn != 6) begin
      errors++; $display("FAIL ignore_counts: got writes=%0d txn=%0d expected 2 6", wr_addr_q.size() - s_wr, n_txn - s_txn);
    end else begin
      checks++;
      if (wr_data_q[s_wr] !== 32'd12 || wr_data_q[s_wr+1] !== 32'd14) begin
        errors++; $display("FAIL ignore_wdata: got %0h %0h expected c e", wr_data_q[s_wr], wr_data_q[s_wr+1]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int lat, cyc, seen; bit to;
    logic [255:0] all;
    @(negedge clk); start_i = 1'b1; vl_i = 4'd3;
    @(negedge clk); start_i = 1'b0;
    seen = 0; cyc = 0;
    while (seen < 2 && cyc < 500) begin
      if (agu_get_rs2_o) seen++;
      if (seen < 2) begin @(negedge clk); cyc++; end
    end
    @(negedge clk);
    checks++;
    if (data_req_o !== 1'b1 || data_we_o !== 1'b0 || data_addr_o !== 32'h204) begin
      errors++; $display("FAIL midrst_in_rs2_req: got req=%b we=%b addr=%0h expected 1 0 204",
                         data_req_o, data_we_o, data_addr_o);
    end
    rst_ni = 1'b0;
    @(negedge clk);
    all = {busy_o, done_o, agu_load_o, agu_get_rs1_o, agu_get_rs2_o, agu_get_rd_o, data_req_o,
           data_we_o, data_addr_o, data_wdata_o, opa_o, opb_o, op_valid_o};
    checks++;
    if (all !== '0) begin errors++; $display("FAIL midrst_outputs: got %0h expected 0", all); end
    rst_ni = 1'b1;
    snap();
    run_op(4'd1, lat, to);
    checks++;
    if (to || lat != 13) begin errors++; $display("FAIL midrst_rerun_latency: got %0d (timeout=%b) expected 13", lat, to); end
    checks++;
    if (wr_addr_q.size() - s_wr != 1 || n_txn - s_txn != 3) begin
      errors++; $display("FAIL midrst_rerun_counts: got writes=%0d txn=%0d expected 1 3", wr_addr_q.size() - s_wr, n_txn - s_txn);
    end else begin
      checks++;
      if (wr_addr_q[s_wr] !== 32'h300 || wr_data_q[s_wr] !== 32'd12) begin
        errors++; $display("FAIL midrst_rerun_write: got %0h<=%0h expected 300<=c", wr_addr_q[s_wr], wr_data_q[s_wr]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < 8; i++) begin
      mem[64 + i]  = 32'(5 + i);
      mem[128 + i] = 32'(7 + i);
    end
    test_reset();
    test_vl_zero();
    test_single();
    test_stall();
    test_clamp();
    test_ignored();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vce2_vrf_seq.md
Name: vce2_vrf_seq

Overview:
- Element sequencer that sits directly upstream of the vector AGU.
- For one element-wise vector op over vl words it does the following:
  - pulses the AGU load, then waits for AGU ready;
  - per element, fetches rs1 and rs2 words from memory, hands them to the ALU, and writes the result back to rd.
- Drives the AGU get_* strobes exactly once per access, so AGU counters advance once per element.
- Latches the AGU address so the OBI-style memory request stays stable until grant.

Parameters:
- DataWidth, 32, data word width.
- AddrWidth, 32, memory address width (must match the AGU).
- VlenWords, 8, maximum element count per vector.
- VlWidth, $clog2(VlenWords+1), width of the vl field.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- start_i  in  1  start vector op; accepted only in IDLE
- vl_i  in  VlWidth  element count; sampled when start is accepted
- busy_o  out  1  sequencer not IDLE
- done_o  out  1  one-cycle completion pulse
- agu_load_o  out  1  AGU parallel-load strobe
- agu_ready_i  in  1  AGU address load complete
- agu_get_rs1_o / agu_get_rs2_o / agu_get_rd_o  out  1 each  AGU generate+increment strobes; at most one high per cycle
- agu_addr_i  in  AddrWidth  AGU address output
- data_req_o  out  1  memory request
- data_gnt_i  in  1  memory grant
- data_rvalid_i  in  1  memory response valid
- data_we_o  out  1  write enable
- data_addr_o  out  AddrWidth  registered request address
- data_wdata_o  out  DataWidth  write data
- data_rdata_i  in  DataWidth  read data
- opa_o / opb_o  out  DataWidth  latched rs1/rs2 operands
- op_valid_o  out  1  operands valid; held until result returns
- res_i  in  DataWidth  ALU result
- res_valid_i  in  1  ALU result valid

Behaviour:
- Reset (rst_ni low at a clock edge, including mid-operation):
  - state returns to IDLE;
  - element counter, vl register, address, operand and result registers clear to 0;
  - every output is 0.
  - An outstanding memory transaction is abandoned; memory and AGU share this reset.
- States and transitions:
  - IDLE:
    - start_i with vl_i==0 → DONE; no AGU load, no memory traffic.
    - start_i with vl_i>0 → AGU_LD; vl is clamped to VlenWords.
  - AGU_LD: agu_load_o=1 for exactly one cycle → AGU_WAIT.
  - AGU_WAIT: on agu_ready_i → RS1_ISS.
  - RS1_ISS / RS2_ISS / RD_ISS:
    - assert the matching agu_get_* for exactly one cycle;
    - capture agu_addr_i into data_addr_o;
    - → the matching _REQ state.
  - _REQ states:
    - data_req_o=1, data_addr_o stable;
    - data_we_o=1 only in RD_REQ, with data_wdata_o = latched result;
    - on data_gnt_i → the matching _RESP state.
  - _RESP states: on data_rvalid_i:
    - RS1 captures data_rdata_i into opa_o → RS2_ISS;
    - RS2 captures into opb_o → EXEC;
    - RD (write ack) increments the element counter; → DONE if the counter equals vl, else → RS1_ISS.
  - EXEC:
    - op_valid_o=1 until res_valid_i;
    - on res_valid_i, latch res_i → RD_ISS.
  - DONE: done_o=1 for one cycle → IDLE.
- Handshake rules:
  - data_rvalid_i is ignored outside _RESP states.
  - res_valid_i is ignored outside EXEC.
  - rvalid can be no earlier than the cycle after gnt.
  - start_i is ignored while busy_o is high.
- busy_o = (state != IDLE), so it is high in DONE.
- Minimum latency, with gnt in the REQ cycle, rvalid in the following cycle, and res_valid in the first EXEC cycle:
  - 10 cycles per element: 3 per access plus 1 EXEC.
  - First RS1_ISS occurs the cycle after agu_ready_i.
- The element counter is VlWidth bits and never wraps, because vl ≤ VlenWords.

Decomposition:
- vce2_pkg holds:
  - typedef enum seq_state_e (IDLE, AGU_LD, AGU_WAIT, RS1_ISS, RS1_REQ, RS1_RESP, RS2_ISS, RS2_REQ, RS2_RESP, EXEC, RD_ISS, RD_REQ, RD_RESP, DONE);
  - default width localparams.
- One sub-module, vce2_mem_port:
  - the REQ/RESP handshake for a single access (addr/we/wdata registers, req until gnt, wait rvalid);
  - reused for all three accesses.

Test Plan:
- vl_i=0, start_i pulse → done_o in the cycle after start; agu_load_o, data_req_o and all get strobes stay 0.
- vl_i=1, immediate gnt, rvalid +1, agu_addr_i sequence 0x100/0x200/0x300 (rs1/rs2/rd), rdata 5 and 7, res_i=12:
  - opa_o=5, opb_o=7;
  - write to 0x300 with wdata 12;
  - exactly one pulse on each agu_get_*;
  - done_o once.
- vl_i=3 with gnt stalled 4 cycles on every request:
  - data_addr_o and data_req_o stable through the stall;
  - each get strobe is 1 cycle wide, 3 pulses each;
  - 9 memory transactions.
- vl_i=12 with VlenWords=8 → clamped: exactly 8 element writes, then done_o.
- start_i re-asserted while busy, plus spurious rvalid during an _ISS state and res_valid_i outside EXEC → all ignored; element count unchanged.
- rst_ni low during RS2_REQ of element 2 → next cycle all outputs 0 and busy_o=0; a new start runs a full clean sequence.
